fpu_issue_sched: RTL and testbench

//  Sequences multi-cycle FPU ops on behalf of the core's execute stage.
//  - Accepts one op per valid/ready handshake and latches its operands.
//  - Waits the per-op settle latency, then presents the result on a valid/ready writeback port.
//  - Sits between the decode/execute FSM and the fadd/fsub/fmul/finv/fsqrt/fcmp/ftoi/itof units.
//  - Replaces the ad-hoc per-instruction latency counters in the execute FSM.

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fpu_issue_sched_if.sv | 26 ++
 rtl/fpu_exec_mux.sv | 136 +++++++++++++
 rtl/fpu_issue_sched.sv | 111 +++++++++++
 tb/tb_fpu_issue_sched.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// FPU scheduler shared definitions: func codes, FSM states,
// per-op latency and writeback target helpers.
package fpu_pkg;

  localparam logic [5:0] FPU_ADD  = 6'h00;
  localparam logic [5:0] FPU_SUB  = 6'h01;
  localparam logic [5:0] FPU_MUL  = 6'h02;
  localparam logic [5:0] FPU_INV  = 6'h03;
  localparam logic [5:0] FPU_SQRT = 6'h04;
  localparam logic [5:0] FPU_ABS  = 6'h05;
  localparam logic [5:0] FPU_NEG  = 6'h06;
  localparam logic [5:0] FPU_EQ   = 6'h08;
  localparam logic [5:0] FPU_LT   = 6'h09;
  localparam logic [5:0] FPU_LE   = 6'h0a;
  localparam logic [5:0] FPU_FTOI = 6'h0c;
  localparam logic [5:0] FPU_ITOF = 6'h0d;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  function automatic int lat_of(logic [5:0] func, int lat_arith, int lat_inv);
    case (func)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_SQRT: return lat_arith;
      FPU_INV: return lat_inv;
      default: return 1;
    endcase
  endfunction

  function automatic logic is_gpr_dst(logic [5:0] func);
    return func inside {FPU_EQ, FPU_LT, FPU_LE, FPU_FTOI};
  endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// Request/writeback handshake bundle between execute stage
// and the FPU scheduler.
interface fpu_issue_sched_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_func;
  logic [4:0]  req_dst;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_dst;
  logic        res_to_gpr;
  logic        res_err;

  modport master (
    output req_valid, req_func, req_dst, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_dst, res_to_gpr, res_err
  );

  modport slave (
    input  req_valid, req_func, req_dst, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_dst, res_to_gpr, res_err
  );
endinterface

// File: rtl/fpu_exec_mux.sv
// Combinational FPU unit bank on latched operands; selects
// the result by func and flags unknown codes.
module fpu_exec_mux
  import fpu_pkg::*;
(
  input  logic [5:0]  func,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        err
);

  // Units truncate and treat denormals as zero.
  function automatic logic [31:0] fadd(logic [31:0] x0, logic [31:0] y0);
    logic [31:0] x, y;
    logic [26:0] mx, my, s;
    logic [9:0]  e;
    if (x0[30:0] >= y0[30:0]) begin
      x = x0;
      y = y0;
    end else begin
      x = y0;
      y = x0;
    end
    mx = {1'b0, x[30:23] != 8'd0, x[22:0], 2'b00};
    my = {1'b0, y[30:23] != 8'd0, y[22:0], 2'b00} >> (x[30:23] - y[30:23]);
    s  = (x[31] == y[31]) ? mx + my : mx - my;
    e  = {2'b00, x[30:23]};
    if (s == 27'd0) return 32'd0;
    if (s[26]) begin
      s = s >> 1;
      e = e + 10'd1;
    end
    for (int i = 0; i < 25; i++)
      if (!s[25]) begin
        s = s << 1;
        e = e - 10'd1;
      end
    if (e[9] || e == 10'd0) return {x[31], 31'd0};
    if (e >= 10'd255) return {x[31], 8'hff, 23'd0};
    return {x[31], e[7:0], s[24:2]};
  endfunction

  function automatic logic [31:0] fmul(logic [31:0] x, logic [31:0] y);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = {2'b00, x[30:23]} + {2'b00, y[30:23]} - 10'd127 + {9'd0, p[47]};
    if (e[9] || e == 10'd0) return {s, 31'd0};
    if (e >= 10'd255) return {s, 8'hff, 23'd0};
    return {s, e[7:0], p[47] ? p[46:24] : p[45:23]};
  endfunction

  function automatic logic [31:0] finv(logic [31:0] x);
    logic [47:0] q;
    logic [9:0]  e;
    if (x[30:23] == 8'd0) return {x[31], 8'hff, 23'd0};
    q = 48'h8000_0000_0000 / {24'd0, 1'b1, x[22:0]};
    e = q[24] ? 10'd254 - {2'b00, x[30:23]} : 10'd253 - {2'b00, x[30:23]};
    if (e[9] || e == 10'd0) return {x[31], 31'd0};
    return {x[31], e[7:0], q[24] ? 23'd0 : q[22:0]};
  endfunction

  function automatic logic [31:0] fsqrt(logic [31:0] x);
    logic [47:0] rad;
    logic [23:0] r, t;
    logic [9:0]  e;
    if (x[30:23] == 8'd0) return {x[31], 31'd0};
    if (x[31]) return 32'h7fc0_0000;
    // Odd unbiased exponent folds one extra bit into the radicand.
    rad = x[23] ? {2'b01, x[22:0], 23'd0} : {1'b1, x[22:0], 24'd0};
    r = 24'd0;
    for (int i = 23; i >= 0; i--) begin
      t = r | (24'd1 << i);
      if ({24'd0, t} * {24'd0, t} <= rad) r = t;
    end
    e = ({2'b00, x[30:23]} + 10'd126 + {9'd0, x[23]}) >> 1;
    return {1'b0, e[7:0], r[22:0]};
  endfunction

  function automatic logic feq(logic [31:0] x, logic [31:0] y);
    return (x == y) || (x[30:0] == 31'd0 && y[30:0] == 31'd0);
  endfunction

  function automatic logic flt(logic [31:0] x, logic [31:0] y);
    if (x[30:0] == 31'd0 && y[30:0] == 31'd0) return 1'b0;
    if (x[31] != y[31]) return x[31];
    return x[31] ? (x[30:0] > y[30:0]) : (x[30:0] < y[30:0]);
  endfunction

  function automatic logic [31:0] ftoi(logic [31:0] x);
    logic [54:0] v;
    logic [31:0] u;
    if (x[30:23] < 8'd127) return 32'd0;
    if (x[30:23] > 8'd157) return x[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    v = {31'd0, 1'b1, x[22:0]} << (x[30:23] - 8'd127);
    u = v[54:23];
    return x[31] ? -u : u;
  endfunction

  function automatic logic [31:0] itof(logic [31:0] x);
    logic [31:0] u, n;
    logic [7:0]  p;
    if (x == 32'd0) return 32'd0;
    u = x[31] ? -x : x;
    p = 8'd0;
    for (int i = 0; i < 32; i++)
      if (u[i]) p = 8'(i);
    n = u << (8'd31 - p);
    return {x[31], 8'd127 + p, n[30:8]};
  endfunction

  always_comb begin
    result = 32'd0;
    err    = 1'b0;
    case (func)
      FPU_ADD:  result = fadd(a, b);
      FPU_SUB:  result = fadd(a, {~b[31], b[30:0]});
      FPU_MUL:  result = fmul(a, b);
      FPU_INV:  result = finv(a);
      FPU_SQRT: result = fsqrt(a);
      FPU_ABS:  result = {1'b0, a[30:0]};
      FPU_NEG:  result = {~a[31], a[30:0]};
      FPU_EQ:   result = {31'd0, feq(a, b)};
      FPU_LT:   result = {31'd0, flt(a, b)};
      FPU_LE:   result = {31'd0, flt(a, b) || feq(a, b)};
      FPU_FTOI: result = ftoi(a);
      FPU_ITOF: result = itof(a);
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_issue_sched.sv
// Multi-cycle FPU op sequencer: accept, settle, write back.
// Define FPU_SCHED_STAT_EN for stat_ops/stat_busy counters.
module fpu_issue_sched
  import fpu_pkg::*;
#(
  parameter int LAT_ARITH = 3,
  parameter int LAT_INV   = 4
`ifdef FPU_SCHED_STAT_EN
  ,
  parameter int STAT_W    = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  fpu_issue_sched_if.slave bus,
  output logic busy
`ifdef FPU_SCHED_STAT_EN
  ,
  output logic [STAT_W-1:0] stat_ops,
  output logic [STAT_W-1:0] stat_busy
`endif
);

  localparam int LAT_MAX = (LAT_ARITH > LAT_INV) ? LAT_ARITH : LAT_INV;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    op_func;
  logic [4:0]    op_dst;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   unit_res;
  logic          unit_err;
  logic          accept;

  // Draining and accepting share one edge, so DONE feeds EXEC directly.
  assign bus.req_ready = (state == IDLE) || (state == DONE && bus.res_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign busy          = (state != IDLE);

  fpu_exec_mux u_exec (
    .func   (op_func),
    .a      (op_a),
    .b      (op_b),
    .result (unit_res),
    .err    (unit_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      op_func        <= '0;
      op_dst         <= '0;
      op_a           <= '0;
      op_b           <= '0;
      bus.res_valid  <= 1'b0;
      bus.res_data   <= '0;
      bus.res_dst    <= '0;
      bus.res_to_gpr <= 1'b0;
      bus.res_err    <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            bus.res_data   <= unit_res;
            bus.res_dst    <= op_dst;
            bus.res_to_gpr <= is_gpr_dst(op_func) && !unit_err;
            bus.res_err    <= unit_err;
            bus.res_valid  <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: ;
      endcase
      if (accept) begin
        op_func     <= bus.req_func;
        op_dst      <= bus.req_dst;
        op_a        <= bus.req_a;
        op_b        <= bus.req_b;
        cnt         <= CW'(lat_of(bus.req_func, LAT_ARITH, LAT_INV) - 1);
        bus.res_err <= 1'b0;
        state       <= EXEC;
      end
    end
  end

`ifdef FPU_SCHED_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_busy <= '0;
    end else begin
      if (accept && stat_ops != '1)
        stat_ops <= stat_ops + STAT_W'(1);
      if (busy && stat_busy != '1)
        stat_busy <= stat_busy + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Scoreboard bench for fpu_issue_sched: expected writebacks
// queued at accept, compared with cycle stamps at res_valid rise.
module tb_fpu_issue_sched;
  import fpu_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  dst;
    logic        gpr;
    logic        err;
    int          at;
  } exp_t;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        g;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];

`ifdef FPU_SCHED_STAT_EN
  logic [31:0] stat_ops;
  logic [31:0] stat_busy;
`endif

  fpu_issue_sched_if bus ();

  fpu_issue_sched #(
    .LAT_ARITH (3),
    .LAT_INV   (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef FPU_SCHED_STAT_EN
    ,
    .stat_ops  (stat_ops),
    .stat_busy (stat_busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_t vecs [11] = '{
    '{FPU_ADD,  32'h3f800000, 32'h40000000, 32'h40400000, 1'b0, 3},
    '{FPU_SUB,  32'h40400000, 32'h3f800000, 32'h40000000, 1'b0, 3},
    '{FPU_MUL,  32'h3fc00000, 32'h3fc00000, 32'h40100000, 1'b0, 3},
    '{FPU_INV,  32'h40000000, 32'h00000000, 32'h3f000000, 1'b0, 4},
    '{FPU_ABS,  32'hc0400000, 32'h00000000, 32'h40400000, 1'b0, 1},
    '{FPU_NEG,  32'h3f800000, 32'h00000000, 32'hbf800000, 1'b0, 1},
    '{FPU_LT,   32'h3f800000, 32'h40000000, 32'h00000001, 1'b1, 1},
    '{FPU_LE,   32'h40000000, 32'h3f800000, 32'h00000000, 1'b1, 1},
    '{FPU_LT,   32'hbf800000, 32'h3f800000, 32'h00000001, 1'b1, 1},
    '{FPU_FTOI, 32'h40400000, 32'h00000000, 32'h00000003, 1'b1, 1},
    '{FPU_ITOF, 32'h00000005, 32'h00000000, 32'h40a00000, 1'b0, 1}
  };

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Call at a negedge; returns #1 after the accept edge.
  task automatic send(input logic [5:0] f, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic g,
                      input logic e, input int lat);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_func  = f;
    bus.req_dst   = d;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("req_accept", {31'd0, bus.req_ready}, 32'd1);
    if (bus.req_ready) q.push_back('{r, d, g, e, cyc + 1 + lat});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("queue_drained", q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (bus.res_valid && !pv) begin
          if (q.size() == 0) begin
            check("res_valid_unexpected", {31'd0, bus.res_valid}, 32'd0);
          end else begin
            e = q.pop_front();
            check("res_data", bus.res_data, e.data);
            check("res_dst", {27'd0, bus.res_dst}, {27'd0, e.dst});
            check("res_to_gpr", {31'd0, bus.res_to_gpr}, {31'd0, e.gpr});
            check("res_err", {31'd0, bus.res_err}, {31'd0, e.err});
            check("latency_cycle", cyc, e.at);
          end
        end
        pv = bus.res_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_func  = '0;
    bus.req_dst   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    #12;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(FPU_MUL, 5'd3, 32'h3fc00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 3);
    drain();

    send(FPU_SQRT, 5'd4, 32'h40800000, 32'h0, 32'h40000000, 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++) begin
      check("exec_req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("exec_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
    end
    drain();

    send(FPU_EQ, 5'd7, 32'h3f800000, 32'h3f800000, 32'h1, 1'b1, 1'b0, 1);
    drain();

    foreach (vecs[i]) begin
      @(negedge clk);
      send(vecs[i].f, 5'(i + 1), vecs[i].a, vecs[i].b, vecs[i].r,
           vecs[i].g, 1'b0, vecs[i].lat);
    end
    drain();

    // Backpressure, then drain and accept on one edge.
    bus.res_ready = 1'b0;
    send(FPU_MUL, 5'd9, 32'h3fc00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 3);
    for (int i = 0; i < 20 && !bus.res_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
      check("hold_res_data", bus.res_data, 32'h40400000);
      check("hold_res_dst", {27'd0, bus.res_dst}, 32'd9);
      check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    send(FPU_ADD, 5'd10, 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 3);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_res_valid", {31'd0, bus.res_valid}, 32'd0);
    drain();

    send(6'b111000, 5'd4, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b1, 1);
    drain();
    check("err_held", {31'd0, bus.res_err}, 32'd1);
    send(FPU_ABS, 5'd12, 32'hc0400000, 32'h0, 32'h40400000, 1'b0, 1'b0, 1);
    check("err_cleared", {31'd0, bus.res_err}, 32'd0);
    drain();

    // Reset while EXEC holds cnt=1.
    send(FPU_MUL, 5'd6, 32'h3fc00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 3);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("mid_rst_res_data", bus.res_data, 32'd0);
    check("mid_rst_res_dst", {27'd0, bus.res_dst}, 32'd0);
    check("mid_rst_res_to_gpr", {31'd0, bus.res_to_gpr}, 32'd0);
    check("mid_rst_res_err", {31'd0, bus.res_err}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_writeback_after_rst", {31'd0, bus.res_valid}, 32'd0);

`ifdef FPU_SCHED_STAT_EN
    check("stat_ops_rst", stat_ops, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      send(FPU_ABS, 5'd1, 32'hbf800000, 32'h0, 32'h3f800000, 1'b0, 1'b0, 1);
    end
    drain();
    check("stat_ops", stat_ops, 32'd4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
